// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline write-back has priority, LSU results queue and drain into free slots.
// Optional `WB_ARB_BYPASS_EN writes an LSU beat straight through when the queue is empty and the slot is free.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pipe_wb_valid,
  input  logic [4:0]                      pipe_wb_rd,
  input  logic [31:0]                     pipe_wb_data,
  output logic                            pipe_stall,
  input  logic                            lsu_wb_valid,
  output logic                            lsu_wb_ready,
  input  logic [4:0]                      lsu_wb_rd,
  input  logic [31:0]                     lsu_wb_data,
  output logic                            reg_write,
  output logic [4:0]                      waddr,
  output logic [31:0]                     wdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t           mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic        empty, full, lsu_live, pipe_live, deq, enq, byp, sel_vld;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign fifo_count   = count;
  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign pipe_stall   = (starve_cnt == SW'(STARVE_LIMIT)) && !empty;
  assign lsu_wb_ready = !reset && !full;
  // rd=0 beats complete the handshake but are dropped here.
  assign lsu_live     = lsu_wb_valid && lsu_wb_ready && (lsu_wb_rd != 5'd0);
  // A forced drain overrides any pipeline write presented alongside it.
  assign pipe_live    = pipe_wb_valid && (pipe_wb_rd != 5'd0) && !pipe_stall;
  assign deq          = !empty && !pipe_live;

`ifdef WB_ARB_BYPASS_EN
  assign byp = lsu_live && empty && !pipe_live;
`else
  assign byp = 1'b0;
`endif

  assign enq = lsu_live && !byp;

  always_comb begin
    sel_vld  = 1'b0;
    sel_rd   = waddr;
    sel_data = wdata;
    if (pipe_live) begin
      sel_vld  = 1'b1;
      sel_rd   = pipe_wb_rd;
      sel_data = pipe_wb_data;
    end else if (deq) begin
      sel_vld  = 1'b1;
      sel_rd   = mem[rptr].rd;
      sel_data = mem[rptr].data;
    end else if (byp) begin
      sel_vld  = 1'b1;
      sel_rd   = lsu_wb_rd;
      sel_data = lsu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= '{rd: lsu_wb_rd, data: lsu_wb_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      reg_write <= sel_vld;
      waddr     <= sel_rd;
      wdata     <= sel_data;
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
      if (empty || deq)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts writes and per-cycle status;
// a negedge monitor pops and compares. Honours `WB_ARB_BYPASS_EN like the design.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_wb_valid = 1'b0;
  logic [4:0]    pipe_wb_rd = '0;
  logic [31:0]   pipe_wb_data = '0;
  logic          pipe_stall;
  logic          lsu_wb_valid = 1'b0;
  logic          lsu_wb_ready;
  logic [4:0]    lsu_wb_rd = '0;
  logic [31:0]   lsu_wb_data = '0;
  logic          reg_write;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic [CW-1:0] fifo_count;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .reg_write(reg_write), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  typedef struct {
    int cnt;
    bit stall;
    bit rdy;
    bit post_rst;
  } stat_t;

  wr_t   wq[$];      // expected register-file writes, in order
  stat_t sq[$];      // expected status, one per cycle
  wr_t   mq[$];      // model of the LSU queue
  int    mst = 0;    // model starvation count
  bit    mprev_rst = 1'b1;
  int    checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // One cycle: record expected status, drive inputs, advance the model past the next edge.
  task automatic step(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit stall, rdy, fire, drained, byp;
    int qs;
    wr_t e;
    @(posedge clk); #1;
    qs    = mq.size();
    stall = (mst == LIMIT) && (qs > 0);
    rdy   = !r && (qs < DEPTH);
    sq.push_back('{cnt: qs, stall: stall, rdy: rdy, post_rst: mprev_rst});
    if (stall) pv = 1'b0;
    reset = r; pipe_wb_valid = pv; pipe_wb_rd = prd; pipe_wb_data = pd;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
    fire = lv && rdy; drained = 0; byp = 0;
    if (r) begin
      mq.delete();
      mst = 0;
    end else begin
      if (stall) begin
        wq.push_back(mq.pop_front()); drained = 1;
      end else if (pv && prd != 0) begin
        e.a = prd; e.d = pd; wq.push_back(e);
      end else if (qs > 0) begin
        wq.push_back(mq.pop_front()); drained = 1;
      end else if (BYP && fire && lrd != 0) begin
        e.a = lrd; e.d = ld; wq.push_back(e); byp = 1;
      end
      if (fire && lrd != 0 && !byp) begin
        e.a = lrd; e.d = ld; mq.push_back(e);
      end
      if (drained || qs == 0) mst = 0;
      else if (mst < LIMIT)   mst++;
    end
    mprev_rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: status every cycle, writes whenever reg_write is presented.
  initial begin
    stat_t s;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("fifo_count", 32'(fifo_count), 32'(s.cnt));
        chk("pipe_stall", 32'(pipe_stall), 32'(s.stall));
        chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(s.rdy));
        chk("protocol_valid_during_stall", 32'(pipe_wb_valid && pipe_stall), 32'd0);
        if (s.post_rst) begin
          chk("rst_reg_write", 32'(reg_write), 32'd0);
          chk("rst_waddr", 32'(waddr), 32'd0);
          chk("rst_wdata", wdata, 32'd0);
        end
      end
      if (reg_write) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(reg_write), 32'd0);
        end else begin
          w = wq.pop_front();
          chk("waddr", 32'(waddr), 32'(w.a));
          chk("wdata", wdata, w.d);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 3, 32'h1);          // valid during reset is not accepted
    // pipeline only, then an rd=0 pipeline write
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 1, 0, 32'h55, 0, 0, 0);
    idle(2);
    // single LSU beat into an empty queue
    step(0, 0, 0, 0, 1, 7, 32'h1234);
    idle(3);
    // fill while the pipeline writes every cycle
    for (int i = 0; i < 6; i++) step(0, 1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 10), 32'h200 + i);
    idle(6);
    // starvation: one queued entry against a continuous pipeline
    step(0, 1, 9, 32'h900, 1, 20, 32'hABCD);
    for (int i = 0; i < 13; i++) step(0, 1, 9, 32'h901 + i, 0, 0, 0);
    idle(3);
    // reach count 2, then enqueue and dequeue together, then an rd=0 LSU beat
    step(0, 1, 4, 32'h40, 1, 21, 32'h2100);
    step(0, 1, 4, 32'h41, 1, 22, 32'h2200);
    step(0, 0, 0, 0, 1, 23, 32'h2300);
    step(0, 1, 4, 32'h42, 1, 0, 32'hDEAD);
    idle(5);
    // reset with three entries queued
    for (int i = 0; i < 3; i++) step(0, 1, 6, 32'h60 + i, 1, 5'(24 + i), 32'h2400 + i);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bit r, pv, lv;
      logic [4:0] prd, lrd;
      r   = ($urandom_range(0, 249) == 0);
      pv  = ($urandom_range(0, 9) < 7);
      lv  = ($urandom_range(0, 9) < 4);
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(r, pv, prd, $urandom, lv, lrd, $urandom);
    end
    idle(20);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("pending_writes", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that merges the in-order pipeline write-back and the load/store unit's out-of-band write-back into the register file's single write port (reg_write/waddr/wdata). Pipeline results always take priority. LSU results queue in a small FIFO and drain into free slots. A starvation counter forces a pipeline bubble so queued LSU results cannot wait indefinitely. The block sits directly upstream of the register file and drives its write port from registered outputs.

## Interface
Parameters:
- FIFO_DEPTH, 4: LSU result queue entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive blocked cycles before a forced drain; at least 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_wb_valid  in  1  pipeline write-back valid; has no backpressure.
- pipe_wb_rd  in  5  pipeline destination register.
- pipe_wb_data  in  32  pipeline result.
- pipe_stall  out  1  forced-drain request; upstream must bubble its write-back slot this cycle.
- lsu_wb_valid  in  1  LSU result valid.
- lsu_wb_ready  out  1  LSU result accepted when valid and ready are both high.
- lsu_wb_rd  in  5  LSU destination register.
- lsu_wb_data  in  32  LSU result.
- reg_write  out  1  register file write enable.
- waddr  out  5  register file write address.
- wdata  out  32  register file write data.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued LSU entries.

## Operation
- Each cycle selects at most one write and registers it into reg_write, waddr and wdata.
- Priority order:
  - forced drain (pipe_stall high): FIFO head;
  - else pipe_wb_valid with rd≠0: pipeline;
  - else FIFO non-empty: FIFO head;
  - else, only with bypass enabled: incoming LSU beat;
  - else reg_write is 0 next cycle.
- rd=0 writes:
  - A pipeline write with rd=0 does not claim the slot. The FIFO may drain in that cycle.
  - An LSU beat with rd=0 is accepted (handshake completes) and discarded; it is never enqueued.
- FIFO:
  - lsu_wb_ready = !reset && (fifo_count < FIFO_DEPTH).
  - Enqueue and dequeue in the same cycle are allowed; fifo_count is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation counter, 0..STARVE_LIMIT:
  - Increments each cycle the FIFO is non-empty and the head is not drained.
  - Clears when the head drains or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- pipe_stall = (starve_cnt == STARVE_LIMIT) && fifo non-empty. It is combinational from registers only.
  - If pipe_wb_valid is high while pipe_stall is high, this is a protocol violation. The FIFO head still wins and the pipeline write is lost.
  - Benches must flag this case.
- Ordering: LSU entries retire in acceptance order. WAW ordering between the pipeline and the LSU is the issue scoreboard's responsibility, not this block's.

## Timing
- Reset: reg_write=0, waddr=0, wdata=0, fifo_count=0, starve_cnt=0, pipe_stall=0, lsu_wb_ready=0.
  - lsu_wb_ready rises in the first cycle after reset deasserts.
- Reset mid-operation flushes queued entries without writing them, and suppresses any write registered in that cycle.
- Pipeline write latency: 1 cycle (input cycle N, reg_write in cycle N+1).
- LSU write latency: minimum 2 cycles (enqueue in N, drain in N+1, reg_write in N+2). With bypass enabled the minimum is 1.
- FIFO full: lsu_wb_ready is 0 in that cycle even if a dequeue occurs in the same cycle. There is no same-cycle pass-through of ready.
- Worst-case wait of a queued head: STARVE_LIMIT+1 cycles from becoming head to drain.

## Configuration
- WB_ARB_BYPASS_EN:
  - Defined: an LSU beat that arrives while the FIFO is empty and the slot is free (no valid rd≠0 pipeline write, no forced drain) is written straight into the output registers. It is not enqueued, and latency is 1.
  - Undefined: every accepted LSU beat passes through the FIFO, and latency is at least 2.

## Test plan
- Pipeline only: pipe rd=5, data=0xDEADBEEF in cycle 0 -> reg_write=1, waddr=5, wdata=0xDEADBEEF in cycle 1. An rd=0 write produces reg_write=0.
- LSU only, FIFO empty: rd=7, data=0x1234 -> reg_write in cycle 2, or in cycle 1 with WB_ARB_BYPASS_EN.
- Fill: 4 LSU beats while the pipeline writes every cycle -> fifo_count=4 and lsu_wb_ready=0. Entries later drain in acceptance order.
- Starvation with STARVE_LIMIT=8:
  - Stimulus: one queued entry while the pipeline writes continuously.
  - Response: pipe_stall=1 on the 9th cycle and the head is written the next cycle.
  - Afterwards starve_cnt=0 and pipe_stall=0.
- Simultaneous enqueue and dequeue at fifo_count=2 -> count stays 2 and the order is preserved. An LSU rd=0 beat is accepted and count is unchanged.
- Reset asserted with 3 entries queued -> next cycle reg_write=0, fifo_count=0, lsu_wb_ready=0. No queued entry is ever written.
